// File: rtl/dzcpu_useq_pkg.sv
// dzcpu_useq_pkg: shared definitions for the dzcpu micro-sequencer.
// Holds the uop field positions, the flow-field encodings, the jcb
// operation code and the sequencer state encodings.
package dzcpu_useq_pkg;

  // uop field boundaries: flow [11:8], operation [7:4], operand [3:0]
  localparam int FLOW_MSB = 11;
  localparam int FLOW_LSB = 8;
  localparam int OPER_MSB = 7;
  localparam int OPER_LSB = 4;
  localparam int OPND_MSB = 3;
  localparam int OPND_LSB = 0;

  // Flow-field encodings
  localparam logic [3:0] FLOW_OP        = 4'd0;
  localparam logic [3:0] FLOW_INC       = 4'd1;
  localparam logic [3:0] FLOW_EOF       = 4'd2;
  localparam logic [3:0] FLOW_INC_EOF   = 4'd3;
  localparam logic [3:0] FLOW_INC_EOF_Z = 4'd4;

  // Operation code that redirects the uPC through the CB LUT
  localparam logic [3:0] OPER_JCB = 4'hC;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_EXEC     = 2'd2
  } state_e;

endpackage

// File: rtl/dzcpu_useq_flow_decode.sv
// dzcpu_useq_flow_decode: combinational decode of the uop flow and
// operation fields into advance / pc_inc / flow_end / cb_jump controls.
// Undefined flow encodings behave like a plain op (advance only).
module dzcpu_useq_flow_decode
  import dzcpu_useq_pkg::*;
(
  input  logic [3:0] flow,
  input  logic [3:0] oper,
  input  logic       z,
  output logic       advance,
  output logic       pc_inc,
  output logic       flow_end,
  output logic       cb_jump
);

  // Flow-field decode; inc_eof_z picks between inc_eof and op on Z
  always_comb begin
    advance  = 1'b0;
    pc_inc   = 1'b0;
    flow_end = 1'b0;
    cb_jump  = (oper == OPER_JCB);
    case (flow)
      FLOW_OP:      advance = 1'b1;
      FLOW_INC: begin
        advance = 1'b1;
        pc_inc  = 1'b1;
      end
      FLOW_EOF:     flow_end = 1'b1;
      FLOW_INC_EOF: begin
        pc_inc   = 1'b1;
        flow_end = 1'b1;
      end
      FLOW_INC_EOF_Z: begin
        advance  = ~z;
        pc_inc   = z;
        flow_end = z;
      end
      default:      advance = 1'b1;
    endcase
  end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: dzcpu micro-sequencer. Owns the uPC, dispatches opcodes
// through the external main/CB LUTs and steps the micro-code ROM one uop
// per cycle. Optional flow watchdog enabled by macro DZCPU_USEQ_WDOG_EN.
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter int UOP_W      = 12,
  parameter int ADDR_W     = 8,
  parameter int WDOG_LIMIT = 32
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [7:0]        iMemData,
  input  logic              iStall,
  input  logic              iZ,
  output logic [7:0]        oMop,
  input  logic [7:0]        iLutIdx,
  output logic [7:0]        oCbMop,
  input  logic [7:0]        iCbLutIdx,
  output logic [ADDR_W-1:0] oUopAddr,
  input  logic [UOP_W-1:0]  iUop,
  output logic [UOP_W-1:0]  oUop,
  output logic              oUopValid,
  output logic              oPcInc,
  output logic              oRetire,
  output logic              oFault
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [7:0]        mop_q, mop_d;
  logic              fault_q, fault_d;

  logic dec_advance, dec_pc_inc, dec_end, dec_cb_jump;
  logic wdog_expire;

  dzcpu_useq_flow_decode u_flow_decode (
    .flow     (iUop[FLOW_MSB:FLOW_LSB]),
    .oper     (iUop[OPER_MSB:OPER_LSB]),
    .z        (iZ),
    .advance  (dec_advance),
    .pc_inc   (dec_pc_inc),
    .flow_end (dec_end),
    .cb_jump  (dec_cb_jump)
  );

`ifdef DZCPU_USEQ_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_LIMIT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Flow counter: cleared on dispatch, counts every executed uop
  always_comb begin
    cnt_d = cnt_q;
    if (!iStall) begin
      if (state_q == ST_DISPATCH) cnt_d = '0;
      else if (state_q == ST_EXEC) cnt_d = cnt_q + 1'b1;
    end
  end

  // Flow counter register
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // The uop executing now is the WDOG_LIMIT-th of this flow
  assign wdog_expire = (cnt_q == CNT_W'(WDOG_LIMIT - 1));
`else
  assign wdog_expire = 1'b0;
`endif

  // Next-state, uPC update and per-uop strobes; a stall freezes everything
  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    mop_d     = mop_q;
    fault_d   = fault_q;
    oUopValid = 1'b0;
    oPcInc    = 1'b0;
    oRetire   = 1'b0;
    if (!iStall) begin
      case (state_q)
        ST_BOOT: state_d = ST_DISPATCH;
        ST_DISPATCH: begin
          mop_d   = iMemData;
          upc_d   = ADDR_W'(iLutIdx);
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          oUopValid = 1'b1;
          oPcInc    = dec_pc_inc;
          if (dec_cb_jump && (iCbLutIdx == 8'd0)) begin
            // illegal CB sub-opcode ends the flow with a fault
            fault_d = 1'b1;
            oRetire = 1'b1;
            state_d = ST_DISPATCH;
          end else if (dec_end && !dec_cb_jump) begin
            oRetire = 1'b1;
            state_d = ST_DISPATCH;
          end else if (wdog_expire) begin
            fault_d = 1'b1;
            oRetire = 1'b1;
            state_d = ST_DISPATCH;
          end else if (dec_cb_jump) begin
            upc_d = ADDR_W'(iCbLutIdx);
          end else if (dec_advance) begin
            upc_d = upc_q + 1'b1;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // Sequencer registers
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= ST_BOOT;
      upc_q   <= '0;
      mop_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      mop_q   <= mop_d;
      fault_q <= fault_d;
    end
  end

  // oMop is transparent in DISPATCH so the main LUT resolves the incoming
  // opcode in the same cycle, and holds the latched opcode otherwise.
  assign oMop     = (state_q == ST_DISPATCH) ? iMemData : mop_q;
  assign oCbMop   = iMemData;
  assign oUopAddr = upc_q;
  assign oUop     = iUop;
  assign oFault   = fault_q;

endmodule

// File: doc/dzcpu_useq.md
# dzcpu_useq

Micro-sequencer for the dzcpu core. It owns the micro-program counter (uPC) and dispatches each fetched opcode through the main and CB opcode LUTs. It steps the micro-code ROM one micro-op (uop) per cycle and issues each uop to the datapath. It also evaluates the uop flow field: advance, PC increment, end-of-flow, conditional end-of-flow, and CB jump. It sits between the memory data bus and opcode LUTs on one side and the micro-code ROM and register/ALU datapath on the other.

## Interface
- UOP_W, 12, uop width; flow field [11:8], operation field [7:4], operand field [3:0]
- ADDR_W, 8, uPC / ROM address width
- WDOG_LIMIT, 32, max uops per flow before forced end (watchdog build only)

- iClock  in  1  core clock
- iReset  in  1  reset, asynchronous, active-low
- iMemData  in  8  memory read data; opcode byte in DISPATCH, CB sub-opcode on a jcb uop
- iStall  in  1  memory/datapath busy; freezes sequencer
- iZ  in  1  datapath Z flag, sampled on inc_eof_z
- oMop  out  8  latched opcode, drives main LUT input
- iLutIdx  in  8  main LUT result
- oCbMop  out  8  CB sub-opcode, equals iMemData, drives CB LUT input
- iCbLutIdx  in  8  CB LUT result
- oUopAddr  out  ADDR_W  ROM address (registered uPC)
- iUop  in  UOP_W  ROM data, combinational from oUopAddr
- oUop  out  UOP_W  uop to datapath (iUop passthrough)
- oUopValid  out  1  oUop is to be executed this cycle
- oPcInc  out  1  one-cycle PC increment strobe
- oRetire  out  1  one-cycle pulse on end of flow
- oFault  out  1  sticky: illegal CB sub-opcode or watchdog expiry

## Operation
- States: BOOT, DISPATCH, EXEC.
- BOOT: one cycle after reset release. Then DISPATCH.
- DISPATCH: oMop <= iMemData, uPC <= iLutIdx (combinational path through LUT), flow counter cleared. Then EXEC.
  - Unknown opcode: LUT returns 0, so flow 0 (generic 1-byte op) runs.
- EXEC, per cycle with iStall=0. oUopValid=1, and the flow field of iUop decides:
  - op: uPC+1.
  - inc: uPC+1, oPcInc=1.
  - eof: oRetire=1, go to DISPATCH.
  - inc_eof: oPcInc=1, oRetire=1, go to DISPATCH.
  - inc_eof_z: if iZ=1, behave as inc_eof; else behave as op.
- jcb in the operation field overrides the uPC update: uPC <= iCbLutIdx.
  - The flow field's oPcInc still applies.
  - If iCbLutIdx=0: set oFault, pulse oRetire, go to DISPATCH.
- uPC arithmetic is modulo 2^ADDR_W. Wrap from 255 to 0 is legal and not flagged.
- iStall=1 in any state: no register update, oUopValid=0, oPcInc=0, oRetire=0. oUopAddr is held.
- oFault clears only on reset.

## Timing
- Reset values: state BOOT, uPC=0, oUopAddr=0, oMop=0, oUopValid=0, oPcInc=0, oRetire=0, oFault=0.
- Flow latency: 1 DISPATCH cycle + N EXEC cycles for an N-uop flow, absent stalls.
- The first uop is valid the cycle after DISPATCH.
- oPcInc and oRetire are combinational from iUop/state and are valid in the same cycle as the uop.
- A CB flow is one continuous EXEC run: the jcb uop is followed directly by the target uop, with no DISPATCH.
- Reset assertion mid-flow aborts immediately. The next flow starts from BOOT. No partial retire pulse.
- iStall rising on the eof cycle: the retire is deferred until the stall releases. Exactly one oRetire per flow.

## Configuration
- DZCPU_USEQ_WDOG_EN defined:
  - A flow counter increments on every executed uop.
  - When the counter reaches WDOG_LIMIT without an end of flow, the sequencer sets oFault, pulses oRetire, and enters DISPATCH.
- Undefined: no counter, the WDOG_LIMIT parameter is unused, and oFault is set by illegal CB only.

## Structure
- Shared package (z80 definitions include) holds:
  - flow encodings: op=0, inc=1, eof=2, inc_eof=3, inc_eof_z=4
  - jcb operation code
  - field MSB/LSB constants
  - state encodings
- One sub-module: dzcpu_useq_flow_decode. It is combinational and maps the flow/operation fields plus iZ to {advance, pc_inc, end, cb_jump}.
- The main and CB LUTs stay external, instantiated beside the sequencer.

## Test plan
- LDSPnn: iMemData=0x31, LUT index 1. Expect oUopAddr 1,2,3,4; oPcInc on all four cycles; oRetire on uPC 4; then DISPATCH.
- JRNZn, iZ=1: index 17. Expect 17,18,19; retire at 19 with oPcInc. Same with iZ=0: expect 17..22, retire at 22, no oPcInc at 19.
- CB 0x7C: 0xCB dispatches to 13; jcb at 15 with iMemData=0x7C. Expect next uPC 16, eof at 16, single oRetire for the whole CB flow.
- CB 0x00 (CB LUT returns 0): expect oFault=1 and oRetire on the jcb cycle, then DISPATCH. oFault stays 1 until reset.
- iStall held 3 cycles at uPC 2 of LDSPnn: oUopAddr stays 2, no strobes. Flow completes 3 cycles late. Reset asserted at uPC 3 of a rerun: all outputs go to reset values asynchronously.
- Watchdog build, WDOG_LIMIT=4, ROM flow of 6 op uops: forced retire after the 4th uop, oFault=1. Non-watchdog build runs all 6.
